// File: rtl/screen_rect_fill.sv
// Rectangle fill engine: turns one fill command into a clipped raster of pixel writes.
// Define RECT_OUTLINE_EN to enable outline-only fills selected by cmd_outline.
module screen_rect_fill #(
  parameter int unsigned SCREEN_SIZE = 128,
  parameter int unsigned PIXEL_GAP   = 2
) (
  input  logic        clk_main,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x0,
  input  logic [6:0]  cmd_y0,
  input  logic [7:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [15:0] cmd_color,
  input  logic        cmd_outline,
  output logic [6:0]  pixel_addr_x,
  output logic [6:0]  pixel_addr_y,
  output logic        pixel_wr_en,
  output logic [15:0] pixel_wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StSetup, StWrite, StGap, StDone} state_e;

  localparam int unsigned GapW = (PIXEL_GAP > 1) ? $clog2(PIXEL_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((PIXEL_GAP == 0) ? 0 : PIXEL_GAP - 1);
  localparam logic [8:0] ScreenLim = 9'(SCREEN_SIZE);

  state_e          state_q, state_d;
  logic [6:0]      x_q, x_d, y_q, y_d;
  logic [6:0]      x0_q, y0_q, x_end_q, y_end_q;
  logic [15:0]     color_q;
  logic            empty_q;
  logic [GapW-1:0] gap_q, gap_d;
  logic            accept;
  logic            x_last, y_last, skip_to_end;

  // 9-bit sums so x0+w (up to 382) cannot wrap before clipping.
  logic [8:0] x_sum, y_sum, x_end_full, y_end_full;
  assign x_sum      = {2'b00, cmd_x0} + {1'b0, cmd_w};
  assign y_sum      = {2'b00, cmd_y0} + {1'b0, cmd_h};
  assign x_end_full = ((x_sum > ScreenLim) ? ScreenLim : x_sum) - 9'd1;
  assign y_end_full = ((y_sum > ScreenLim) ? ScreenLim : y_sum) - 9'd1;

  logic unused_end_bits;
  assign unused_end_bits = ^{x_end_full[8:7], y_end_full[8:7]};

  assign x_last = (x_q == x_end_q);
  assign y_last = (y_q == y_end_q);

`ifdef RECT_OUTLINE_EN
  logic outline_q;
  always_ff @(posedge clk_main) begin
    if (!rst_n) begin
      outline_q <= 1'b0;
    end else if (accept) begin
      outline_q <= cmd_outline;
    end
  end
  // Interior rows of an outline only touch the two edge columns.
  assign skip_to_end = outline_q && (x_q == x0_q) && (y_q != y0_q) && !y_last;
`else
  logic unused_outline;
  assign unused_outline = cmd_outline;
  assign skip_to_end    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    gap_d       = gap_q;
    accept      = 1'b0;
    cmd_ready   = 1'b0;
    pixel_wr_en = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (enable) begin
          if (empty_q) begin
            state_d = StDone;
          end else begin
            x_d     = x0_q;
            y_d     = y0_q;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (enable) begin
          pixel_wr_en = 1'b1;
          if (x_last && y_last) begin
            state_d = StDone;
          end else begin
            if (x_last) begin
              x_d = x0_q;
              y_d = y_q + 7'd1;
            end else if (skip_to_end) begin
              x_d = x_end_q;
            end else begin
              x_d = x_q + 7'd1;
            end
            gap_d   = '0;
            state_d = (PIXEL_GAP == 0) ? StWrite : StGap;
          end
        end
      end
      StGap: begin
        if (enable) begin
          if (gap_q == GapLast) begin
            state_d = StWrite;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      color_q <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
      if (accept) begin
        x0_q    <= cmd_x0;
        y0_q    <= cmd_y0;
        x_end_q <= x_end_full[6:0];
        y_end_q <= y_end_full[6:0];
        color_q <= cmd_color;
        empty_q <= (cmd_w == 8'd0) || (cmd_h == 8'd0);
      end
    end
  end

  assign pixel_addr_x  = x_q;
  assign pixel_addr_y  = y_q;
  assign pixel_wr_data = color_q;
  assign busy          = (state_q != StIdle);

endmodule
